// File: rtl/draw_pkg.sv
// ---------------------------------------------------------------------------
// draw_pkg : shared types for the drawing-priority stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package draw_pkg;

  localparam int RGB_W = 12;

  typedef logic [RGB_W-1:0] rgb_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_SWAP   = 2'd2
  } sched_state_e;

  function automatic int layer_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/layer_perm_mux.sv
// ---------------------------------------------------------------------------
// layer_perm_mux : rank->layer inverse map with masked draw and RGB select
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module layer_perm_mux
  import draw_pkg::*;
#(
  parameter int SIZE = 4,
  parameter int LW   = layer_w(SIZE)
) (
  input  logic [SIZE-1:0][LW-1:0] rank_i,
  input  logic [SIZE-1:0]         draw_i,
  input  logic [SIZE-1:0]         en_i,
  input  logic [SIZE-1:0]         blink_i,
  input  rgb_t [SIZE-1:0]         rgb_i,
  input  logic                    blink_phase_i,
  output logic [SIZE-1:0]         draw_o,
  output rgb_t [SIZE-1:0]         rgb_o
);

  // The rank table is a permutation, so exactly one layer matches each slot.
  always_comb begin
    draw_o = '0;
    rgb_o  = '0;
    for (int r = 0; r < SIZE; r++) begin
      for (int l = 0; l < SIZE; l++) begin
        if (rank_i[l] == LW'(r)) begin
          draw_o[r] = draw_i[l] & en_i[l] & ~(blink_i[l] & blink_phase_i);
          rgb_o[r]  = rgb_i[l];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/layer_priority_sched.sv
// ---------------------------------------------------------------------------
// layer_priority_sched : shadowed rank/enable/blink table with frame-atomic commit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module layer_priority_sched
  import draw_pkg::*;
#(
  parameter  int SIZE         = 4,
  parameter  int BLINK_FRAMES = 16,
  localparam int LW           = layer_w(SIZE),
  localparam int FW           = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic [SIZE-1:0]        draw_in,
  input  rgb_t [SIZE-1:0]        RGB_in,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [LW-1:0]          cfg_layer,
  input  logic [LW-1:0]          cfg_rank,
  input  logic                   cfg_en,
  input  logic                   cfg_blink,
  output logic [SIZE-1:0]        draw_out,
  output rgb_t [SIZE-1:0]        RGB_out,
  output logic                   blink_phase
);

  sched_state_e            state_q, state_d;
  logic [LW-1:0]           lay_q, lay_d;
  logic [LW-1:0]           rank_q, rank_d;
  logic                    en_q, en_d;
  logic                    blink_q, blink_d;
  logic [LW-1:0]           idx_q, idx_d;
  logic [LW-1:0]           j_q, j_d;

  logic [SIZE-1:0][LW-1:0] sh_rank_q, sh_rank_d;
  logic [SIZE-1:0]         sh_en_q, sh_en_d;
  logic [SIZE-1:0]         sh_blink_q, sh_blink_d;
  logic [SIZE-1:0][LW-1:0] act_rank_q;
  logic [SIZE-1:0]         act_en_q;
  logic [SIZE-1:0]         act_blink_q;

  logic [FW-1:0]           cnt_q;
  logic                    phase_q;
  logic [SIZE-1:0]         draw_q;
  rgb_t [SIZE-1:0]         rgb_q;

  logic [SIZE-1:0]         mux_draw;
  rgb_t [SIZE-1:0]         mux_rgb;
  logic                    cfg_ok;

  assign cfg_ok = (int'(cfg_layer) < SIZE) && (int'(cfg_rank) < SIZE);

  always_comb begin
    state_d    = state_q;
    lay_d      = lay_q;
    rank_d     = rank_q;
    en_d       = en_q;
    blink_d    = blink_q;
    idx_d      = idx_q;
    j_d        = j_q;
    sh_rank_d  = sh_rank_q;
    sh_en_d    = sh_en_q;
    sh_blink_d = sh_blink_q;
    cfg_ready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        // Out-of-range requests are consumed without touching the tables.
        if (cfg_valid && cfg_ok) begin
          lay_d   = cfg_layer;
          rank_d  = cfg_rank;
          en_d    = cfg_en;
          blink_d = cfg_blink;
          idx_d   = '0;
          state_d = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (sh_rank_q[idx_q] == rank_q) j_d = idx_q;
        if (idx_q == LW'(SIZE - 1)) state_d = ST_SWAP;
        else                        idx_d   = idx_q + 1'b1;
      end
      ST_SWAP: begin
        // Layer j gives up the target rank; writing lay_q last covers j == lay_q.
        sh_rank_d[j_q]      = sh_rank_q[lay_q];
        sh_rank_d[lay_q]    = rank_q;
        sh_en_d[lay_q]      = en_q;
        sh_blink_d[lay_q]   = blink_q;
        state_d             = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      lay_q       <= '0;
      rank_q      <= '0;
      en_q        <= 1'b0;
      blink_q     <= 1'b0;
      idx_q       <= '0;
      j_q         <= '0;
      for (int i = 0; i < SIZE; i++) begin
        sh_rank_q[i]  <= LW'(i);
        act_rank_q[i] <= LW'(i);
      end
      sh_en_q     <= '1;
      sh_blink_q  <= '0;
      act_en_q    <= '1;
      act_blink_q <= '0;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      draw_q      <= '0;
      rgb_q       <= '0;
    end else begin
      state_q    <= state_d;
      lay_q      <= lay_d;
      rank_q     <= rank_d;
      en_q       <= en_d;
      blink_q    <= blink_d;
      idx_q      <= idx_d;
      j_q        <= j_d;
      sh_rank_q  <= sh_rank_d;
      sh_en_q    <= sh_en_d;
      sh_blink_q <= sh_blink_d;
      // Commit only from IDLE so a half-applied swap never reaches the screen.
      if (startOfFrame && state_q == ST_IDLE) begin
        act_rank_q  <= sh_rank_q;
        act_en_q    <= sh_en_q;
        act_blink_q <= sh_blink_q;
      end
      if (startOfFrame) begin
        if (cnt_q == FW'(BLINK_FRAMES - 1)) begin
          cnt_q   <= '0;
          phase_q <= ~phase_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      draw_q <= mux_draw;
      rgb_q  <= mux_rgb;
    end
  end

  layer_perm_mux #(
    .SIZE (SIZE),
    .LW   (LW)
  ) u_perm_mux (
    .rank_i        (act_rank_q),
    .draw_i        (draw_in),
    .en_i          (act_en_q),
    .blink_i       (act_blink_q),
    .rgb_i         (RGB_in),
    .blink_phase_i (phase_q),
    .draw_o        (mux_draw),
    .rgb_o         (mux_rgb)
  );

  assign draw_out    = draw_q;
  assign RGB_out     = rgb_q;
  assign blink_phase = phase_q;

endmodule

`default_nettype wire

// File: tb/tb_layer_priority_sched.sv
// ---------------------------------------------------------------------------
// tb_layer_priority_sched : directed self-checking bench for layer_priority_sched
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_layer_priority_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetN = 1'b0;

  // Main instance: SIZE=4, BLINK_FRAMES=2
  logic             startOfFrame = 1'b0;
  logic [3:0]       draw_in = '0;
  logic [3:0][11:0] RGB_in = '0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_layer = '0;
  logic [1:0]       cfg_rank = '0;
  logic             cfg_en = 1'b0;
  logic             cfg_blink = 1'b0;
  logic [3:0]       draw_out;
  logic [3:0][11:0] RGB_out;
  logic             blink_phase;

  // Range-check instance: SIZE=5 (3-bit config fields), BLINK_FRAMES=1
  logic             b_sof = 1'b0;
  logic [4:0]       b_draw_in = '0;
  logic [4:0][11:0] b_RGB_in = '0;
  logic             b_cfg_valid = 1'b0;
  logic             b_cfg_ready;
  logic [2:0]       b_cfg_layer = '0;
  logic [2:0]       b_cfg_rank = '0;
  logic [4:0]       b_draw_out;
  logic [4:0][11:0] b_RGB_out;
  logic             b_blink_phase;

  int checks   = 0;
  int failures = 0;

  layer_priority_sched #(.SIZE(4), .BLINK_FRAMES(2)) u_dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .draw_in      (draw_in),
    .RGB_in       (RGB_in),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_layer    (cfg_layer),
    .cfg_rank     (cfg_rank),
    .cfg_en       (cfg_en),
    .cfg_blink    (cfg_blink),
    .draw_out     (draw_out),
    .RGB_out      (RGB_out),
    .blink_phase  (blink_phase)
  );

  layer_priority_sched #(.SIZE(5), .BLINK_FRAMES(1)) u_dut_b (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (b_sof),
    .draw_in      (b_draw_in),
    .RGB_in       (b_RGB_in),
    .cfg_valid    (b_cfg_valid),
    .cfg_ready    (b_cfg_ready),
    .cfg_layer    (b_cfg_layer),
    .cfg_rank     (b_cfg_rank),
    .cfg_en       (1'b1),
    .cfg_blink    (1'b0),
    .draw_out     (b_draw_out),
    .RGB_out      (b_RGB_out),
    .blink_phase  (b_blink_phase)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof_pulse();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic cfg_send(input logic [1:0] layer, input logic [1:0] rank,
                          input logic en, input logic blink);
    cfg_layer = layer;
    cfg_rank  = rank;
    cfg_en    = en;
    cfg_blink = blink;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!cfg_ready && n < 20) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] blink_draw  [4] = '{4'b1101, 4'b0101, 4'b0101, 4'b1101};
    logic       blink_phs   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 4; i++) RGB_in[i]   = 12'(i * 256 + 1);
    for (int i = 0; i < 5; i++) b_RGB_in[i] = 12'(i * 256 + 1);

    // Reset state
    repeat (2) tick();
    check_eq("rst_ready",  cfg_ready, 1'b1);
    check_eq("rst_draw",   draw_out, 4'b0000);
    check_eq("rst_rgb",    RGB_out, 48'h0);
    check_eq("rst_phase",  blink_phase, 1'b0);
    resetN = 1'b1;

    // 1: identity mapping, one-cycle latency
    draw_in = 4'b0101;
    tick();
    check_eq("t1_draw",  draw_out, 4'b0101);
    check_eq("t1_rgb2",  RGB_out[2], 12'h201);
    check_eq("t1_rgb0",  RGB_out[0], 12'h001);

    // 2: layer3 -> rank0, layer0 displaced to rank3
    draw_in = 4'b1000;
    cfg_send(2'd3, 2'd0, 1'b1, 1'b0);
    wait_ready(n);
    check_eq("t2_busy", 64'(n), 64'd5);
    tick();
    check_eq("t2_precommit", draw_out, 4'b1000);
    sof_pulse();
    tick();
    check_eq("t2_draw",  draw_out, 4'b0001);
    check_eq("t2_rgb0",  RGB_out[0], 12'h301);
    check_eq("t2_rgb3",  RGB_out[3], 12'h001);
    check_eq("t2_phase", blink_phase, 1'b0);

    // 3: frame start during SEARCH skips the commit
    draw_in = 4'b0100;
    cfg_send(2'd2, 2'd3, 1'b1, 1'b0);
    sof_pulse();
    wait_ready(n);
    check_eq("t3_busy", 64'(n), 64'd4);
    tick();
    check_eq("t3_nocommit", draw_out, 4'b0100);
    check_eq("t3_phase",    blink_phase, 1'b1);
    sof_pulse();
    tick();
    check_eq("t3_commit", draw_out, 4'b1000);
    check_eq("t3_rgb3",   RGB_out[3], 12'h201);

    // 4: disable layer1 at its own rank; ranks stay put
    draw_in = 4'b1111;
    cfg_send(2'd1, 2'd1, 1'b0, 1'b0);
    wait_ready(n);
    check_eq("t4_busy", 64'(n), 64'd5);
    sof_pulse();
    tick();
    check_eq("t4_draw",  draw_out, 4'b1101);
    check_eq("t4_rgb1",  RGB_out[1], 12'h101);
    check_eq("t4_rgb2",  RGB_out[2], 12'h001);
    check_eq("t4_phase", blink_phase, 1'b0);

    // 5: blink on layer2 (rank3), phase toggles every second frame
    cfg_send(2'd2, 2'd3, 1'b1, 1'b1);
    wait_ready(n);
    check_eq("t5_busy", 64'(n), 64'd5);
    for (int k = 0; k < 4; k++) begin
      sof_pulse();
      tick();
      check_eq($sformatf("t5_phase%0d", k), blink_phase, blink_phs[k]);
      check_eq($sformatf("t5_draw%0d", k),  draw_out,    blink_draw[k]);
    end

    // 6a: reset mid-SEARCH aborts the write and restores identity
    cfg_send(2'd0, 2'd2, 1'b1, 1'b0);
    tick();
    resetN = 1'b0;
    #1;
    check_eq("t6_rst_ready", cfg_ready, 1'b1);
    check_eq("t6_rst_draw",  draw_out, 4'b0000);
    check_eq("t6_rst_phase", blink_phase, 1'b0);
    tick();
    resetN  = 1'b1;
    draw_in = 4'b0101;
    tick();
    check_eq("t6_draw", draw_out, 4'b0101);
    check_eq("t6_rgb2", RGB_out[2], 12'h201);
    sof_pulse();
    tick();
    check_eq("t6_after_sof", draw_out, 4'b0101);
    check_eq("t6_rgb0",      RGB_out[0], 12'h001);

    // 6b: out-of-range requests consumed in one cycle, tables untouched
    b_draw_in   = 5'b00010;
    b_cfg_layer = 3'd5;
    b_cfg_rank  = 3'd0;
    b_cfg_valid = 1'b1;
    tick();
    check_eq("t6_layer_oor_ready", b_cfg_ready, 1'b1);
    b_cfg_layer = 3'd1;
    b_cfg_rank  = 3'd7;
    tick();
    check_eq("t6_rank_oor_ready", b_cfg_ready, 1'b1);
    b_cfg_valid = 1'b0;
    b_sof       = 1'b1;
    tick();
    b_sof = 1'b0;
    tick();
    check_eq("t6_oor_draw",  b_draw_out, 5'b00010);
    check_eq("t6_oor_rgb1",  b_RGB_out[1], 12'h101);
    check_eq("t6_oor_phase", b_blink_phase, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
